// File: rtl/shift_register_fifo_v2_if.sv
// rtl/shift_register_fifo_v2_if.sv - control, data and status bundle for the shift-register FIFO
// master drives requests and write data; slave (the FIFO) returns data and occupancy flags.
interface shift_register_fifo_v2_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, push, pop, data_in,
        input  data_out, count, empty, full, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  clr, push, pop, data_in,
        output data_out, count, empty, full, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/shift_register_fifo_v2.sv
// rtl/shift_register_fifo_v2.sv - shift-register FIFO, newest word enters entry 0
// oldest word sits at entry[count-1]; sticky overflow/underflow cleared by rst or clr.
module shift_register_fifo_v2 #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_LEVEL  = DEPTH - 1,
    parameter int AE_LEVEL  = 1,
    parameter int OVERWRITE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    shift_register_fifo_v2_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] entries_q [DEPTH];
    logic [WIDTH-1:0] entries_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;
    logic             shift_en;
    logic             is_empty;
    logic             is_full;
    logic [WIDTH-1:0] head;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        shift_en    = 1'b0;
        if (bus.clr) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (bus.push && bus.pop) begin
            // At count 0 the pop has nothing to consume, so only the push lands.
            shift_en = 1'b1;
            if (is_empty) begin
                count_d     = CW'(1);
                underflow_d = 1'b1;
            end
        end else if (bus.push) begin
            if (!is_full) begin
                shift_en = 1'b1;
                count_d  = count_q + CW'(1);
            end else begin
                overflow_d = 1'b1;
                shift_en   = (OVERWRITE != 0);
            end
        end else if (bus.pop) begin
            if (is_empty) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_comb begin
        entries_d = entries_q;
        if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
        end else if (shift_en) begin
            entries_d[0] = bus.data_in;
            for (int i = 1; i < DEPTH; i++) begin
                entries_d[i] = entries_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            entries_q   <= entries_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i + 1)) begin
                head = entries_q[i];
            end
        end
    end

    assign bus.data_out     = head;
    assign bus.count        = count_q;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_shift_register_fifo_v2.sv
// tb/tb_shift_register_fifo_v2.sv - bench for shift_register_fifo_v2, DEPTH=4, both OVERWRITE modes
// two DUTs share stimulus; each is compared against its own queue model.
module tb_shift_register_fifo_v2;
    localparam int W     = 8;
    localparam int D     = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic clk;
    logic rst;

    shift_register_fifo_v2_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
    shift_register_fifo_v2_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

    shift_register_fifo_v2 #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .OVERWRITE(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    shift_register_fifo_v2 #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .OVERWRITE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] mq [2][$];
    bit           mov [2];
    bit           mun [2];

    logic [W-1:0] seq4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [W-1:0] ow0  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [W-1:0] ow1  [4] = '{8'h22, 8'h33, 8'h44, 8'h55};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void reset_model();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mov[k] = 1'b0;
            mun[k] = 1'b0;
        end
    endfunction

    function automatic void model_step(input int k, input bit p, input bit o, input bit c, input logic [W-1:0] d);
        int n;
        n = mq[k].size();
        if (c) begin
            mq[k].delete();
            mov[k] = 1'b0;
            mun[k] = 1'b0;
        end else if (p && o) begin
            if (n == 0) begin
                mun[k] = 1'b1;
            end else begin
                void'(mq[k].pop_front());
            end
            mq[k].push_back(d);
        end else if (p) begin
            if (n < D) begin
                mq[k].push_back(d);
            end else begin
                mov[k] = 1'b1;
                if (k == 1) begin
                    void'(mq[k].pop_front());
                    mq[k].push_back(d);
                end
            end
        end else if (o) begin
            if (n > 0) void'(mq[k].pop_front());
            else mun[k] = 1'b1;
        end
    endfunction

    task automatic check_dut(input int k, input logic [W-1:0] dout, input logic [2:0] cnt,
                             input logic e, input logic f, input logic af, input logic ae,
                             input logic ov, input logic un);
        int n;
        string p;
        n = mq[k].size();
        p = $sformatf("dut%0d.", k);
        check_eq({p, "data_out"}, dout, (n > 0) ? mq[k][0] : 8'h00);
        check_eq({p, "count"}, cnt, n);
        check_eq({p, "empty"}, e, n == 0);
        check_eq({p, "full"}, f, n == D);
        check_eq({p, "almost_full"}, af, n >= AF);
        check_eq({p, "almost_empty"}, ae, n <= AE);
        check_eq({p, "overflow"}, ov, mov[k]);
        check_eq({p, "underflow"}, un, mun[k]);
    endtask

    task automatic check_all();
        check_dut(0, bus0.data_out, bus0.count, bus0.empty, bus0.full, bus0.almost_full,
                  bus0.almost_empty, bus0.overflow, bus0.underflow);
        check_dut(1, bus1.data_out, bus1.count, bus1.empty, bus1.full, bus1.almost_full,
                  bus1.almost_empty, bus1.overflow, bus1.underflow);
    endtask

    task automatic set_inputs(input bit p, input bit o, input bit c, input logic [W-1:0] d);
        bus0.push = p; bus0.pop = o; bus0.clr = c; bus0.data_in = d;
        bus1.push = p; bus1.pop = o; bus1.clr = c; bus1.data_in = d;
    endtask

    task automatic drive(input bit p, input bit o, input bit c, input logic [W-1:0] d);
        @(negedge clk);
        set_inputs(p, o, c, d);
        @(posedge clk);
        #1;
        model_step(0, p, o, c, d);
        model_step(1, p, o, c, d);
        check_all();
    endtask

    task automatic fill4();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, seq4[i]);
    endtask

    initial begin
        rst = 1'b1;
        set_inputs(1'b0, 1'b0, 1'b0, 8'h00);
        reset_model();
        #1;
        check_eq("rst_count", bus0.count, 0);
        check_eq("rst_empty", bus0.empty, 1);
        check_eq("rst_almost_empty", bus0.almost_empty, 1);
        check_eq("rst_full", bus0.full, 0);
        check_eq("rst_almost_full", bus0.almost_full, 0);
        check_eq("rst_data_out", bus0.data_out, 0);
        check_eq("rst_count_ow", bus1.count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // In-order push/pop and threshold edges
        drive(1'b1, 1'b0, 1'b0, seq4[0]);
        check_eq("thr_ae_at1", bus0.almost_empty, 1);
        drive(1'b1, 1'b0, 1'b0, seq4[1]);
        check_eq("thr_ae_at2", bus0.almost_empty, 0);
        check_eq("thr_af_at2", bus0.almost_full, 0);
        drive(1'b1, 1'b0, 1'b0, seq4[2]);
        check_eq("thr_af_at3", bus0.almost_full, 1);
        drive(1'b1, 1'b0, 1'b0, seq4[3]);
        check_eq("order_full", bus0.full, 1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("order_pop%0d", i), bus0.data_out, seq4[i]);
            drive(1'b0, 1'b1, 1'b0, 8'h00);
        end
        check_eq("order_empty", bus0.empty, 1);

        // Push at full: drop vs overwrite
        fill4();
        drive(1'b1, 1'b0, 1'b0, 8'h55);
        check_eq("ovf_flag0", bus0.overflow, 1);
        check_eq("ovf_flag1", bus1.overflow, 1);
        check_eq("ovf_count0", bus0.count, 4);
        check_eq("ovf_count1", bus1.count, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("ovf_drop_pop%0d", i), bus0.data_out, ow0[i]);
            check_eq($sformatf("ovf_over_pop%0d", i), bus1.data_out, ow1[i]);
            drive(1'b0, 1'b1, 1'b0, 8'h00);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        check_eq("clr_overflow", bus0.overflow, 0);

        // Simultaneous push/pop at count 2
        drive(1'b1, 1'b0, 1'b0, 8'h11);
        drive(1'b1, 1'b0, 1'b0, 8'h22);
        check_eq("pp_head_before", bus0.data_out, 8'h11);
        drive(1'b1, 1'b1, 1'b0, 8'hAA);
        check_eq("pp_count", bus0.count, 2);
        check_eq("pp_next_head", bus0.data_out, 8'h22);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("pp_last", bus0.data_out, 8'hAA);
        drive(1'b0, 1'b1, 1'b0, 8'h00);

        // Underflow and its clear
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("udf_flag", bus0.underflow, 1);
        check_eq("udf_count", bus0.count, 0);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        check_eq("udf_clr", bus0.underflow, 0);

        // Push+pop on empty
        drive(1'b1, 1'b1, 1'b0, 8'h3C);
        check_eq("pp_empty_count", bus0.count, 1);
        check_eq("pp_empty_udf", bus0.underflow, 1);

        // Random traffic alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 400; i++) begin
            bit p;
            bit o;
            bit c;
            bit heavy;
            heavy = ((i / 40) % 2) == 0;
            p = $urandom_range(0, 3) < (heavy ? 3 : 1);
            o = $urandom_range(0, 3) < (heavy ? 1 : 3);
            c = $urandom_range(0, 39) == 0;
            drive(p, o, c, 8'($urandom));
        end

        // Asynchronous reset between edges at count 3
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        fill4();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("arst_pre_count", bus0.count, 3);
        set_inputs(1'b1, 1'b0, 1'b0, 8'h77);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_count", bus0.count, 0);
        check_eq("arst_empty", bus0.empty, 1);
        check_eq("arst_data_out", bus0.data_out, 0);
        check_eq("arst_almost_full", bus0.almost_full, 0);
        reset_model();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        set_inputs(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h77);
        check_eq("arst_resume_count", bus0.count, 1);
        check_eq("arst_resume_head", bus0.data_out, 8'h77);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
